// File: rtl/mul_unit_scheduler_pkg.sv
// Shared types and helpers for the RV32M multiply scheduler: operation encoding,
// datapath width and the sign-handling rules for each multiply flavour.
package mul_unit_scheduler_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        MUL    = 2'b00,
        MULH   = 2'b01,
        MULHSU = 2'b10,
        MULHU  = 2'b11
    } mul_op_e;

    // Operand A is signed for MULH and MULHSU, operand B only for MULH.
    function automatic logic a_is_signed(input mul_op_e op);
        return (op == MULH) || (op == MULHSU);
    endfunction

    function automatic logic b_is_signed(input mul_op_e op);
        return (op == MULH);
    endfunction

    function automatic logic [XLEN-1:0] twos_neg(input logic [XLEN-1:0] x);
        return ~x + 32'd1;
    endfunction

endpackage

// File: rtl/mul_unit_scheduler_if.sv
// Request/result bundle between the two issue lanes, writeback and the multiply
// scheduler. The core side is the master; the scheduler is the slave.
interface mul_unit_scheduler_if
    import mul_unit_scheduler_pkg::*;
#(
    parameter int TAG_W = 5
);
    logic                flush;
    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    mul_op_e             req_op  [2];
    logic [XLEN-1:0]     req_rs1 [2];
    logic [XLEN-1:0]     req_rs2 [2];
    logic [TAG_W-1:0]    req_tag [2];
    logic                out_valid;
    logic                out_ready;
    logic                out_lane;
    logic [TAG_W-1:0]    out_tag;
    logic [XLEN-1:0]     out_data;

    modport master (
        output flush, req_valid, req_op, req_rs1, req_rs2, req_tag, out_ready,
        input  req_ready, out_valid, out_lane, out_tag, out_data
    );

    modport slave (
        input  flush, req_valid, req_op, req_rs1, req_rs2, req_tag, out_ready,
        output req_ready, out_valid, out_lane, out_tag, out_data
    );
endinterface

// File: rtl/full_adder_64bit.sv
// 64-bit adder with optional inversion of B; with A=0, Invert_B=1, C_in=1 it
// produces the two's-complement negation of B.
module full_adder_64bit (
    input  logic [63:0] A,
    input  logic [63:0] B,
    input  logic        Invert_B,
    input  logic        C_in,
    output logic [63:0] Sum
);
    logic [63:0] b_eff;

    assign b_eff = Invert_B ? ~B : B;
    assign Sum   = A + b_eff + {{63{1'b0}}, C_in};
endmodule

// File: rtl/multiplier_32X32.sv
// Unsigned 32x32 -> 64 array multiplier shared by both issue lanes.
module multiplier_32X32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] p
);
    assign p = {32'd0, a} * {32'd0, b};
endmodule

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter. The pointer names the lane favoured when both
// request and moves to the other lane only when a grant is actually taken.
module rr_arbiter_2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);
    logic ptr_reg;

    assign grant[0] = req[0] & (!req[1] | !ptr_reg);
    assign grant[1] = req[1] & (!req[0] |  ptr_reg);

    // Favour the lane that was not just served.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg <= 1'b0;
        end else if (advance) begin
            ptr_reg <= grant[0];
        end
    end
endmodule

// File: rtl/mul_unit_scheduler.sv
// Shares one unsigned multiplier between two issue lanes: S1 captures operand
// magnitudes and result sign, S2 multiplies, re-signs and selects the result half.
module mul_unit_scheduler
    import mul_unit_scheduler_pkg::*;
#(
    parameter int TAG_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    mul_unit_scheduler_if.slave  bus
);
    logic [1:0]       grant;
    logic             s1_valid_reg;
    logic             s2_valid_reg;
    logic             s2_adv;
    logic             s1_adv;
    logic             accept;
    logic             sel;

    mul_op_e          sel_op;
    logic [XLEN-1:0]  sel_a;
    logic [XLEN-1:0]  sel_b;
    logic             sel_a_neg;
    logic             sel_b_neg;
    logic [XLEN-1:0]  s1_a_next;
    logic [XLEN-1:0]  s1_b_next;

    logic [XLEN-1:0]  s1_a_reg;
    logic [XLEN-1:0]  s1_b_reg;
    logic             s1_neg_reg;
    mul_op_e          s1_op_reg;
    logic [TAG_W-1:0] s1_tag_reg;
    logic             s1_lane_reg;

    logic [63:0]      prod;
    logic [63:0]      prod_neg;
    logic [63:0]      prod_signed;
    logic [XLEN-1:0]  out_data_next;

    logic [XLEN-1:0]  out_data_reg;
    logic [TAG_W-1:0] out_tag_reg;
    logic             out_lane_reg;

    assign s2_adv = !s2_valid_reg || bus.out_ready;
    assign s1_adv = !s1_valid_reg || s2_adv;

    rr_arbiter_2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (bus.req_valid),
        .advance (accept),
        .grant   (grant)
    );

    // Nothing is accepted while in reset or in a flush cycle.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ready
            assign bus.req_ready[gi] = grant[gi] & s1_adv & !bus.flush & !rst;
        end
    endgenerate

    assign accept = |bus.req_ready;
    assign sel    = grant[1];

    assign sel_op    = bus.req_op[sel];
    assign sel_a     = bus.req_rs1[sel];
    assign sel_b     = bus.req_rs2[sel];
    assign sel_a_neg = a_is_signed(sel_op) & sel_a[XLEN-1];
    assign sel_b_neg = b_is_signed(sel_op) & sel_b[XLEN-1];

    // 0x80000000 negates to itself, which is the correct unsigned magnitude.
    assign s1_a_next = sel_a_neg ? twos_neg(sel_a) : sel_a;
    assign s1_b_next = sel_b_neg ? twos_neg(sel_b) : sel_b;

    multiplier_32X32 u_mul (
        .a (s1_a_reg),
        .b (s1_b_reg),
        .p (prod)
    );

    full_adder_64bit u_neg (
        .A        (64'd0),
        .B        (prod),
        .Invert_B (1'b1),
        .C_in     (1'b1),
        .Sum      (prod_neg)
    );

    assign prod_signed   = s1_neg_reg ? prod_neg : prod;
    assign out_data_next = (s1_op_reg == MUL) ? prod_signed[XLEN-1:0] : prod_signed[63:XLEN];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s2_valid_reg <= 1'b0;
            s1_a_reg     <= '0;
            s1_b_reg     <= '0;
            s1_neg_reg   <= 1'b0;
            s1_op_reg    <= MUL;
            s1_tag_reg   <= '0;
            s1_lane_reg  <= 1'b0;
            out_data_reg <= '0;
            out_tag_reg  <= '0;
            out_lane_reg <= 1'b0;
        end else if (bus.flush) begin
            // Flush wins over out_ready: a result taken this cycle is dropped.
            s1_valid_reg <= 1'b0;
            s2_valid_reg <= 1'b0;
        end else begin
            if (s2_adv) begin
                s2_valid_reg <= s1_valid_reg;
                if (s1_valid_reg) begin
                    out_data_reg <= out_data_next;
                    out_tag_reg  <= s1_tag_reg;
                    out_lane_reg <= s1_lane_reg;
                end
            end
            if (s1_adv) begin
                s1_valid_reg <= accept;
                if (accept) begin
                    s1_a_reg    <= s1_a_next;
                    s1_b_reg    <= s1_b_next;
                    s1_neg_reg  <= sel_a_neg ^ sel_b_neg;
                    s1_op_reg   <= sel_op;
                    s1_tag_reg  <= bus.req_tag[sel];
                    s1_lane_reg <= sel;
                end
            end
        end
    end

    assign bus.out_valid = s2_valid_reg;
    assign bus.out_data  = out_data_reg;
    assign bus.out_tag   = out_tag_reg;
    assign bus.out_lane  = out_lane_reg;

endmodule

// File: tb/tb_mul_unit_scheduler.sv
// Directed bench for mul_unit_scheduler: hand-computed RV32M results, round-robin
// order, backpressure, flush and asynchronous reset.
module tb_mul_unit_scheduler;
    import mul_unit_scheduler_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    mul_unit_scheduler_if #(.TAG_W(5)) bus ();

    mul_unit_scheduler #(.TAG_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int lane, input mul_op_e op, input logic [31:0] a,
                            input logic [31:0] b, input logic [4:0] tag);
        bus.req_valid[lane] = 1'b1;
        bus.req_op[lane]    = op;
        bus.req_rs1[lane]   = a;
        bus.req_rs2[lane]   = b;
        bus.req_tag[lane]   = tag;
    endtask

    task automatic check_result(input string name, input logic lane, input logic [4:0] tag,
                                input logic [31:0] data);
        check({name, "_vld"},  64'(bus.out_valid), 64'd1);
        check({name, "_data"}, 64'(bus.out_data),  64'(data));
        check({name, "_lane"}, 64'(bus.out_lane),  64'(lane));
        check({name, "_tag"},  64'(bus.out_tag),   64'(tag));
    endtask

    // Single op on an otherwise idle pipe: presented in cycle N, result after edge N+2.
    task automatic run_single(input string name, input int lane, input mul_op_e op,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [4:0] tag, input logic [31:0] exp);
        bus.req_valid = 2'b00;
        set_lane(lane, op, a, b, tag);
        #1;
        check({name, "_rdy"}, 64'(bus.req_ready), (lane == 1) ? 64'd2 : 64'd1);
        step();
        bus.req_valid = 2'b00;
        #1;
        check({name, "_early"}, 64'(bus.out_valid), 64'd0);
        step();
        check_result(name, lane[0], tag, exp);
        step();
        check({name, "_once"}, 64'(bus.out_valid), 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        n_checks      = 0;
        n_pass        = 0;
        rst           = 1'b1;
        bus.flush     = 1'b0;
        bus.req_valid = 2'b00;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus.req_op[i]  = MUL;
            bus.req_rs1[i] = '0;
            bus.req_rs2[i] = '0;
            bus.req_tag[i] = '0;
        end
        step();
        step();
        check("rst_vld",  64'(bus.out_valid), 64'd0);
        check("rst_data", 64'(bus.out_data),  64'd0);
        check("rst_tag",  64'(bus.out_tag),   64'd0);
        check("rst_lane", 64'(bus.out_lane),  64'd0);
        check("rst_rdy",  64'(bus.req_ready), 64'd0);
        rst = 1'b0;
        step();

        // Sign handling across the four flavours.
        run_single("mulh_min",   0, MULH,   32'h8000_0000, 32'h8000_0000, 5'd1, 32'h4000_0000);
        run_single("mulhsu_m1",  1, MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFF);
        run_single("mulhu_max",  1, MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFE);
        run_single("mul_7xm3",   0, MUL,    32'h0000_0007, 32'hFFFF_FFFD, 5'd4, 32'hFFFF_FFEB);
        run_single("mul_zero",   1, MUL,    32'h0000_0000, 32'hFFFF_FFFF, 5'd5, 32'h0000_0000);
        run_single("mulh_neg",   0, MULH,   32'hFFFF_FFFD, 32'h0000_0007, 5'd6, 32'hFFFF_FFFF);
        run_single("mulh_negneg",1, MULH,   32'hFFFF_FFFD, 32'hFFFF_FFFD, 5'd7, 32'h0000_0000);
        run_single("mulh_pos",   0, MULH,   32'h7FFF_FFFF, 32'h7FFF_FFFF, 5'd8, 32'h3FFF_FFFF);

        // Both lanes streaming from reset: lane0 first, then alternating.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            if (i < 4) begin
                set_lane(0, MUL, 32'd3, 32'd5, 5'h0A);
                set_lane(1, MUL, 32'd4, 32'd6, 5'h15);
            end else begin
                bus.req_valid = 2'b00;
            end
            #1;
            if (i < 4)
                check($sformatf("rr_rdy%0d", i), 64'(bus.req_ready), (i % 2 == 0) ? 64'd1 : 64'd2);
            if (i >= 2 && i < 6) begin
                if ((i % 2) == 0) check_result($sformatf("rr_out%0d", i), 1'b0, 5'h0A, 32'd15);
                else              check_result($sformatf("rr_out%0d", i), 1'b1, 5'h15, 32'd24);
            end
            if (i == 6) check("rr_drained", 64'(bus.out_valid), 64'd0);
            step();
        end

        // Backpressure with two ops in flight and a third waiting.
        bus.out_ready = 1'b0;
        set_lane(0, MULHU, 32'hFFFF_FFFF, 32'h0000_0002, 5'd11);
        #1;
        check("st_rdyA", 64'(bus.req_ready), 64'd1);
        step();
        bus.req_valid = 2'b00;
        set_lane(1, MUL, 32'd6, 32'd7, 5'd12);
        #1;
        check("st_rdyB", 64'(bus.req_ready), 64'd2);
        step();
        bus.req_valid = 2'b00;
        set_lane(0, MUL, 32'd2, 32'd3, 5'd13);
        for (int i = 0; i < 3; i++) begin
            #1;
            check_result($sformatf("st_hold%0d", i), 1'b0, 5'd11, 32'd1);
            check($sformatf("st_rdy%0d", i), 64'(bus.req_ready), 64'd0);
            step();
        end
        bus.out_ready = 1'b1;
        #1;
        check_result("st_relA", 1'b0, 5'd11, 32'd1);
        check("st_rdyC", 64'(bus.req_ready), 64'd1);
        step();
        bus.req_valid = 2'b00;
        #1;
        check_result("st_outB", 1'b1, 5'd12, 32'd42);
        step();
        check_result("st_outC", 1'b0, 5'd13, 32'd6);
        step();
        check("st_drained", 64'(bus.out_valid), 64'd0);

        // Flush with S1 and S2 both occupied; pointer left favouring lane1.
        set_lane(1, MUL, 32'd9, 32'd9, 5'd20);
        step();
        bus.req_valid = 2'b00;
        set_lane(0, MUL, 32'd8, 32'd8, 5'd21);
        step();
        bus.flush = 1'b1;
        set_lane(0, MUL, 32'd5, 32'd5, 5'd22);
        #1;
        check("fl_vld_before", 64'(bus.out_valid), 64'd1);
        check("fl_rdy", 64'(bus.req_ready), 64'd0);
        step();
        bus.flush = 1'b0;
        set_lane(0, MUL, 32'd5, 32'd5, 5'd22);
        set_lane(1, MUL, 32'd10, 32'd11, 5'd23);
        #1;
        check("fl_vld_after", 64'(bus.out_valid), 64'd0);
        check("fl_ptr", 64'(bus.req_ready), 64'd2);
        step();
        bus.req_valid = 2'b00;
        #1;
        check("fl_ghost", 64'(bus.out_valid), 64'd0);
        step();
        check_result("fl_new", 1'b1, 5'd23, 32'd110);
        step();
        check("fl_drained", 64'(bus.out_valid), 64'd0);

        // Asynchronous reset while results are in flight.
        set_lane(0, MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7);
        step();
        step();
        check("ar_vld_before", 64'(bus.out_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("ar_vld",  64'(bus.out_valid), 64'd0);
        check("ar_data", 64'(bus.out_data),  64'd0);
        check("ar_tag",  64'(bus.out_tag),   64'd0);
        check("ar_lane", 64'(bus.out_lane),  64'd0);
        check("ar_rdy",  64'(bus.req_ready), 64'd0);
        step();
        rst = 1'b0;
        bus.req_valid = 2'b00;
        step();
        check("ar_quiet0", 64'(bus.out_valid), 64'd0);
        step();
        check("ar_quiet1", 64'(bus.out_valid), 64'd0);
        set_lane(0, MUL, 32'd1, 32'd1, 5'd1);
        set_lane(1, MUL, 32'd1, 32'd1, 5'd2);
        #1;
        check("ar_ptr", 64'(bus.req_ready), 64'd1);
        step();
        bus.req_valid = 2'b00;
        step();
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
